// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath/memory port.
// The master side is the sequencer; state is exposed for checkers and debug.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    // Memory handshake: mem_req is held stable (with iord/mem_we) until a rising
    // edge where mem_req and mem_ready are both high; that edge completes the request.
    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RISC-V core: steps each instruction through
// fetch/decode/execute/memory/writeback, counts retirements and traps unknown opcodes.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_LOAD_WB   = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       in_fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    state_t           state;
    state_t           nxt;
    ctrl_t            ctrl;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // Control word for a state; registered against the next state so outputs are glitch-free.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.in_fetch  = 1'b1;
                c.alu_src_b = 2'd1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'd2;
                c.alu_src_b = 2'd2;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'd1;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'd1;
                c.alu_src_b = 2'd2;
                c.alu_op    = 2'b11;
            end
            S_ALU_WB:  c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.alu_src_a = 2'd1;
                c.alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_LOAD_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = 2'd1;
            end
            S_MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 2'd1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'd1;
            end
            S_JAL: begin
                c.reg_write = 1'b1;
                c.wb_sel    = 2'd2;
                c.pc_write  = 1'b1;
                c.pc_src    = 2'd1;
            end
            S_JALR: begin
                c.alu_src_a = 2'd1;
                c.alu_src_b = 2'd2;
                c.reg_write = 1'b1;
                c.wb_sel    = 2'd2;
                c.pc_write  = 1'b1;
                c.pc_src    = 2'd2;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            S_RESET:  nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    7'b0110011:             nxt = S_EXEC_R;
                    7'b0010011:             nxt = S_EXEC_I;
                    7'b0000011, 7'b0100011: nxt = S_MEM_ADDR;
                    7'b1100011:             nxt = S_BRANCH;
                    7'b1101111:             nxt = S_JAL;
                    7'b1100111:             nxt = S_JALR;
                    default:                nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = bus.opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: if (bus.mem_ready) nxt = S_LOAD_WB;
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL, S_JALR: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            ctrl      <= '0;
            retired_q <= '0;
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt);
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // IR and PC load in FETCH track the memory response within the same cycle.
    assign bus.ir_write      = ctrl.in_fetch & bus.mem_ready;
    assign bus.pc_write      = ctrl.pc_write | (ctrl.in_fetch & bus.mem_ready);
    assign bus.mem_req       = ctrl.mem_req;
    assign bus.mem_we        = ctrl.mem_we;
    assign bus.iord          = ctrl.iord;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.wb_sel        = ctrl.wb_sel;
    assign bus.illegal       = ctrl.illegal;
    assign bus.retired       = retired_q;
    assign bus.state         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle control words predicted from the state table
// are queued as each cycle is driven and compared against the sequencer outputs.
module tb_multicycle_control;

    localparam int W = 22;
    localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2,
                           ST_EXEC_R = 4'd3, ST_EXEC_I = 4'd4, ST_ALU_WB = 4'd5,
                           ST_MEM_ADDR = 4'd6, ST_MEM_READ = 4'd7, ST_LOAD_WB = 4'd8,
                           ST_MEM_WRITE = 4'd9, ST_BRANCH = 4'd10, ST_JAL = 4'd11,
                           ST_JALR = 4'd12, ST_TRAP = 4'd13;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BAD = 7'b0000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) bus ();
    multicycle_control #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_retired;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] observe();
        return {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.wb_sel, bus.illegal};
    endfunction

    // Expected outputs per state, written straight from the state table.
    function automatic logic [W-1:0] model(input logic [3:0] st, input logic mr);
        logic mreq, mwe, io, irw, pcw, pcwc, rw, ill;
        logic [1:0] pcs, sa, sb, op, wb;
        mreq = 0; mwe = 0; io = 0; irw = 0; pcw = 0; pcwc = 0; rw = 0; ill = 0;
        pcs = 0; sa = 0; sb = 0; op = 0; wb = 0;
        case (st)
            ST_FETCH:     begin mreq = 1; sb = 2'd1; irw = mr; pcw = mr; end
            ST_DECODE:    begin sa = 2'd2; sb = 2'd2; end
            ST_EXEC_R:    begin sa = 2'd1; sb = 2'd0; op = 2'b10; end
            ST_EXEC_I:    begin sa = 2'd1; sb = 2'd2; op = 2'b11; end
            ST_ALU_WB:    begin rw = 1; wb = 2'd0; end
            ST_MEM_ADDR:  begin sa = 2'd1; sb = 2'd2; end
            ST_MEM_READ:  begin mreq = 1; io = 1; end
            ST_LOAD_WB:   begin rw = 1; wb = 2'd1; end
            ST_MEM_WRITE: begin mreq = 1; mwe = 1; io = 1; end
            ST_BRANCH:    begin sa = 2'd1; op = 2'b01; pcwc = 1; pcs = 2'd1; end
            ST_JAL:       begin rw = 1; wb = 2'd2; pcw = 1; pcs = 2'd1; end
            ST_JALR:      begin sa = 2'd1; sb = 2'd2; rw = 1; wb = 2'd2; pcw = 1; pcs = 2'd2; end
            ST_TRAP:      ill = 1;
            default:      ;
        endcase
        return {st, mreq, mwe, io, irw, pcw, pcwc, pcs, sa, sb, op, rw, wb, ill};
    endfunction

    // One clock cycle: drive mem_ready, queue the prediction, compare mid-cycle.
    task automatic step(input logic [3:0] st, input logic mr, input string tag);
        bus.mem_ready = mr;
        exp_q.push_back(model(st, mr));
        @(negedge clk);
        check(tag, observe(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input string tag);
        bus.opcode = opc;
        for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, {tag, "_fetch_wait"});
        step(ST_FETCH, 1'b1, {tag, "_fetch"});
        step(ST_DECODE, rnd(), {tag, "_decode"});
        case (opc)
            OP_R: begin
                step(ST_EXEC_R, rnd(), {tag, "_exec_r"});
                step(ST_ALU_WB, rnd(), {tag, "_alu_wb"});
            end
            OP_I: begin
                step(ST_EXEC_I, rnd(), {tag, "_exec_i"});
                step(ST_ALU_WB, rnd(), {tag, "_alu_wb"});
            end
            OP_LD: begin
                step(ST_MEM_ADDR, rnd(), {tag, "_mem_addr"});
                for (int i = 0; i < mw; i++) step(ST_MEM_READ, 1'b0, {tag, "_rd_wait"});
                step(ST_MEM_READ, 1'b1, {tag, "_mem_read"});
                step(ST_LOAD_WB, rnd(), {tag, "_load_wb"});
            end
            OP_ST: begin
                step(ST_MEM_ADDR, rnd(), {tag, "_mem_addr"});
                for (int i = 0; i < mw; i++) step(ST_MEM_WRITE, 1'b0, {tag, "_wr_wait"});
                step(ST_MEM_WRITE, 1'b1, {tag, "_mem_write"});
            end
            OP_BR:   step(ST_BRANCH, rnd(), {tag, "_branch"});
            OP_JAL:  step(ST_JAL, rnd(), {tag, "_jal"});
            OP_JALR: step(ST_JALR, rnd(), {tag, "_jalr"});
            default: begin
                for (int i = 0; i < 22; i++) step(ST_TRAP, rnd(), {tag, "_trap"});
            end
        endcase
        if (opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR}) begin
            exp_retired = exp_retired + 32'd1;
            check({tag, "_next_fetch"}, bus.state, ST_FETCH);
        end
        check({tag, "_retired"}, bus.retired, exp_retired);
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
        exp_retired = '0;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = OP_R;
        #1;

        // Reset held with mem_ready high, then one RESET cycle after release.
        step(ST_RESET, 1'b1, "reset_hold0");
        step(ST_RESET, 1'b1, "reset_hold1");
        check("reset_retired", bus.retired, 32'd0);
        reset = 1'b0;
        step(ST_RESET, 1'b1, "reset_release");

        run_instr(OP_R, 0, 0, "r_type");
        run_instr(OP_LD, 2, 2, "load_wait");
        run_instr(OP_ST, 0, 0, "store");
        run_instr(OP_BR, 0, 0, "branch");
        run_instr(OP_JAL, 0, 0, "jal");
        run_instr(OP_I, 0, 0, "i_type");
        run_instr(OP_JALR, 0, 0, "jalr");
        for (int k = 0; k < 8; k++)
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3), "rand");

        // Counter wrap from all-ones.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_retired = 32'hFFFF_FFFF;
        check("wrap_preload", bus.retired, exp_retired);
        run_instr(OP_R, 0, 0, "wrap");

        // Asynchronous reset in the middle of a load's memory wait.
        bus.opcode = OP_LD;
        step(ST_FETCH, 1'b1, "abort_fetch");
        step(ST_DECODE, 1'b0, "abort_decode");
        step(ST_MEM_ADDR, 1'b0, "abort_mem_addr");
        bus.mem_ready = 1'b0;
        #2;
        check("abort_req_before", bus.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_req_dropped", bus.mem_req, 1'b0);
        check("abort_state", bus.state, ST_RESET);
        check("abort_retired", bus.retired, 32'd0);
        exp_retired = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(ST_RESET, 1'b1, "abort_restart");
        run_instr(OP_R, 1, 0, "after_abort");

        // Unsupported opcode traps until reset.
        run_instr(OP_BAD, 0, 0, "illegal");
        reset = 1'b1;
        #1;
        check("illegal_cleared", bus.illegal, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_retired = '0;
        step(ST_RESET, 1'b1, "trap_restart");
        run_instr(OP_I, 0, 0, "after_trap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
